// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-encoding arbiter: defaults and the encoder function.
package gray_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int GRAY_MAXW = 64;

  // Callers zero-extend into GRAY_MAXW and slice back; the zero MSB makes bit WIDTH-1 pass through.
  function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction
endpackage

// File: rtl/gray_conv_arbiter_if.sv
// Requester/consumer bundle for gray_conv_arbiter; slave is the arbiter side.
interface gray_conv_arbiter_if
  import gray_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req_vec at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_vec,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        w_sum = {1'b0, ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
        w_idx = w_sum[IDW-1:0];
        if (!any && req_vec[w_idx]) begin
          any                 = 1'b1;
          gnt_idx             = w_idx;
          gnt_onehot[w_idx]   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary-to-Gray encoder with a single registered, id-tagged output slot.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_conv_arbiter_if.slave   bus
);
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data,  w_data_nxt;
  logic [IDW-1:0]   r_id,    w_id_nxt;
  logic [IDW-1:0]   r_rr_ptr, w_ptr_nxt;

  logic             w_out_valid;
  logic             w_slot_free;
  logic [NREQ-1:0]  w_gnt_oh;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_words [NREQ];
  logic [WIDTH-1:0] w_gray;

  for (genvar i = 0; i < NREQ; i++) begin : g_words
    assign w_words[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  assign w_out_valid = (r_state == S_FULL);
  assign w_slot_free = !w_out_valid || bus.out_ready;

  // Gating with rst keeps a word presented during reset from being handshaken.
  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_vec    (bus.req_valid),
    .ptr        (r_rr_ptr),
    .en         (w_slot_free && !rst),
    .gnt_onehot (w_gnt_oh),
    .gnt_idx    (w_gnt_idx),
    .any        (w_accept)
  );

  assign w_gray = WIDTH'(bin2gray(GRAY_MAXW'(w_words[w_gnt_idx])));

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_rr_ptr;
    if (w_accept) begin
      w_state_nxt = S_FULL;
      w_data_nxt  = w_gray;
      w_id_nxt    = w_gnt_idx;
      w_ptr_nxt   = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
    end else if (w_out_valid && bus.out_ready) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_data   <= '0;
      r_id     <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_data   <= w_data_nxt;
      r_id     <= w_id_nxt;
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign bus.req_ready = w_gnt_oh;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_id    = r_id;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed vector bench for gray_conv_arbiter (NREQ=4, WIDTH=4).
module tb_gray_conv_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_conv_arbiter_if #(.NREQ(4), .WIDTH(4)) bus ();

  gray_conv_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  e_ready;
    logic        e_ovalid;
    logic [3:0]  e_odata;
    logic [1:0]  e_oid;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [15:0] d, logic o,
                              logic [3:0] er, logic eov, logic [3:0] eod, logic [1:0] eid);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.ordy = o;
    t.e_ready = er; t.e_ovalid = eov; t.e_odata = eod; t.e_oid = eid;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, check req_ready before the rising edge, then the slot after it.
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    rst           = v.rst;
    bus.req_valid = v.valid;
    bus.req_data  = v.data;
    bus.out_ready = v.ordy;
    #1;
    chk("req_ready", idx, 32'(bus.req_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    chk("out_valid", idx, 32'(bus.out_valid), 32'(v.e_ovalid));
    chk("out_data",  idx, 32'(bus.out_data),  32'(v.e_odata));
    chk("out_id",    idx, 32'(bus.out_id),    32'(v.e_oid));
  endtask

  function automatic logic [3:0] gray4(logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    for (int i = 0; i < 3; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;

    // reset held two cycles, then idle
    tbl.push_back(mk(1, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b0000, 16'h0000, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'b0000, 0));
    // single requester
    tbl.push_back(mk(0, 4'b0001, 16'h0003, 1, 4'b0001, 1, 4'b0010, 0));
    tbl.push_back(mk(0, 4'b0001, 16'h0001, 1, 4'b0001, 1, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h0001, 1, 4'b0000, 0, 4'b0001, 0));
    // reset with requests pending, then full round robin
    tbl.push_back(mk(1, 4'b1111, 16'h4321, 1, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'b0011, 1));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'b0010, 2));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b1000, 1, 4'b0110, 3));
    // backpressure for five cycles, release accepts with no bubble
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0001, 1, 4'b0001, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0010, 1, 4'b0011, 1));
    // wrap-around: serve 2 so ptr=3, then 1010 grants 3 then 1, ptr ends at 2
    tbl.push_back(mk(0, 4'b0100, 16'h4321, 1, 4'b0100, 1, 4'b0010, 2));
    tbl.push_back(mk(0, 4'b1010, 16'h4321, 1, 4'b1000, 1, 4'b0110, 3));
    tbl.push_back(mk(0, 4'b1010, 16'h4321, 1, 4'b0010, 1, 4'b0011, 1));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 1, 4'b0100, 1, 4'b0010, 2));
    // reset while full and stalled
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 0, 4'b0000, 1, 4'b0010, 2));
    tbl.push_back(mk(1, 4'b1111, 16'h4321, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 16'h4321, 0, 4'b0001, 1, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h4321, 1, 4'b0000, 0, 4'b0001, 0));
    // extreme data values and hold-while-full then drain
    tbl.push_back(mk(0, 4'b0100, 16'h0F00, 1, 4'b0100, 1, 4'b1000, 2));
    tbl.push_back(mk(0, 4'b1001, 16'h800A, 1, 4'b1000, 1, 4'b1100, 3));
    tbl.push_back(mk(0, 4'b1001, 16'h800A, 1, 4'b0001, 1, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h800A, 0, 4'b0000, 1, 4'b1111, 0));
    tbl.push_back(mk(0, 4'b0000, 16'h800A, 1, 4'b0000, 0, 4'b1111, 0));

    foreach (tbl[i]) step(tbl[i], i);

    // Back-to-back stream from ptr=1 with fresh data every cycle
    for (int k = 0; k < 8; k++) begin
      vec_t v;
      logic [15:0] d;
      int g;
      for (int i = 0; i < 4; i++) d[i*4 +: 4] = 4'((k*4 + i + 5) & 15);
      g = (1 + k) % 4;
      v = mk(0, 4'b1111, d, 1, 4'(1 << g), 1, gray4(d[g*4 +: 4]), 2'(g));
      step(v, 100 + k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
